dmem_initiator: RTL and testbench

Load/store initiator for the data-memory port: accepts one load or store per handshake from the execute/memory stage, drives the cache request pins (memread, memwrite, addr, write_data, sign_mask), tracks the cache's clk_stall busy window, and returns loaded data with a one-cycle response pulse. Sits between the core's memory stage and the data cache. Issues one outstanding access at a time, with no pipelining.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_mask_enc.sv | 33 +++
 rtl/dmem_initiator.sv | 135 +++++++++++++
 tb/tb_dmem_initiator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory load/store initiator.
// The optional misalignment check is enabled by defining DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // [3] sign-extend, [2:0] access size (byte 001, half 011, word 111)
    localparam logic [3:0] SIGN_MASK_B   = 4'b1001;
    localparam logic [3:0] SIGN_MASK_BU  = 4'b0001;
    localparam logic [3:0] SIGN_MASK_H   = 4'b1011;
    localparam logic [3:0] SIGN_MASK_HU  = 4'b0011;
    localparam logic [3:0] SIGN_MASK_W   = 4'b1111;
    localparam logic [3:0] SIGN_MASK_ILL = 4'b0111;

    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] addr_lo);
        return ((mask[2:0] == SIZE_HALF) && addr_lo[0]) ||
               ((mask[2:0] == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_mask_enc.sv
// Maps RV32I funct3 and the store flag to the cache sign_mask encoding.
// Unsupported funct3 values fall back to a word access with no sign extension.
module dmem_mask_enc
    import dmem_pkg::*;
(
    input  logic       i_we,
    input  logic [2:0] i_funct3,
    output logic [3:0] o_sign_mask
);

    always_comb begin
        o_sign_mask = SIGN_MASK_ILL;
        if (i_we) begin
            // Stores carry no sign information; only the size matters.
            case (i_funct3)
                F3_B:    o_sign_mask = SIGN_MASK_BU;
                F3_H:    o_sign_mask = SIGN_MASK_HU;
                F3_W:    o_sign_mask = SIGN_MASK_W;
                default: o_sign_mask = SIGN_MASK_ILL;
            endcase
        end else begin
            case (i_funct3)
                F3_B:    o_sign_mask = SIGN_MASK_B;
                F3_BU:   o_sign_mask = SIGN_MASK_BU;
                F3_H:    o_sign_mask = SIGN_MASK_H;
                F3_HU:   o_sign_mask = SIGN_MASK_HU;
                F3_W:    o_sign_mask = SIGN_MASK_W;
                default: o_sign_mask = SIGN_MASK_ILL;
            endcase
        end
    end

endmodule

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store initiator between the memory stage and the data cache.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses without a cache strobe.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int STALL_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic [3:0]  sign_mask,
    input  logic [31:0] read_data,
    input  logic        clk_stall,
    output logic [2:0]  o_dbg_state
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(STALL_TIMEOUT);

    state_t     r_state;
    logic       r_we;
    logic       r_misalign;
    logic [7:0] r_cnt;

    logic [3:0] w_mask;
    logic       w_misalign;
    logic       w_fire;
    logic [7:0] w_cnt_next;

    dmem_mask_enc u_mask_enc (
        .i_we        (req_we),
        .i_funct3    (req_funct3),
        .o_sign_mask (w_mask)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = is_misaligned(w_mask, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
    // the requester holds req_valid and its payload until then, and ready is never offered while busy.
    assign req_ready   = (r_state == ST_IDLE) && !clk_stall;
    assign w_fire      = req_valid && req_ready;
    assign w_cnt_next  = r_cnt + 8'd1;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            addr       <= '0;
            write_data <= '0;
            sign_mask  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_we       <= req_we;
                        r_misalign <= w_misalign;
                        addr       <= req_addr;
                        write_data <= req_wdata;
                        sign_mask  <= w_mask;
                        // Strobes are registered so they are high exactly during ISSUE.
                        memread    <= !req_we && !w_misalign;
                        memwrite   <= req_we && !w_misalign;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_misalign) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    r_cnt <= w_cnt_next;
                    if (clk_stall) begin
                        r_state <= ST_WAIT_LO;
                    end else if (w_cnt_next == TIMEOUT_CNT) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WAIT_LO: begin
                    if (!clk_stall) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_we ? 32'd0 : read_data;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_cnt      <= '0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// Randomized bench for dmem_initiator against a cycle-count reference model of the access timeline.
// Honours DMEM_MISALIGN_CHECK_EN when the build defines it.
module tb_dmem_initiator;
    import dmem_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  sign_mask;
    logic [31:0] read_data = '0;
    logic        clk_stall = 1'b0;
    logic [2:0]  o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    dmem_initiator #(.STALL_TIMEOUT(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .o_dbg_state(o_dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: sign_mask table straight from the load/store encoding rules.
    function automatic logic [3:0] model_mask(input logic we, input logic [2:0] f3);
        if (we) begin
            case (f3)
                3'b000:  return 4'b0001;
                3'b001:  return 4'b0011;
                3'b010:  return 4'b1111;
                default: return 4'b0111;
            endcase
        end
        case (f3)
            3'b000:  return 4'b1001;
            3'b100:  return 4'b0001;
            3'b001:  return 4'b1011;
            3'b101:  return 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic bit model_misalign(input logic [3:0] m, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (m[2:0] == 3'b011 && a[0]) || (m[2:0] == 3'b111 && a[1:0] != 2'b00);
`else
        return 1'b0 && (m != 4'd0) && (a != 32'd0);
`endif
    endfunction

    // Driver: one access. Cycle 0 is the handshake cycle; the cache raises clk_stall
    // rd cycles after the strobe cycle, for len cycles (never raised when 'never' is set).
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] ld,
                              input int rd, input int len, input bit never);
        logic [3:0]  m;
        bit          mis;
        int          resp_c;
        int          cap_c;
        bit          exp_err;
        int          strobes;
        bit          held_ok;
        logic [31:0] exp_rdata;
        m       = model_mask(we, f3);
        mis     = model_misalign(m, a);
        strobes = 0;
        held_ok = 1'b1;
        if (mis) begin
            resp_c  = 2;
            exp_err = 1'b1;
        end else if (never) begin
            resp_c  = T + 2;
            exp_err = 1'b1;
        end else begin
            cap_c   = (2 + rd > 1 + rd + len) ? 2 + rd : 1 + rd + len;
            resp_c  = cap_c + 1;
            exp_err = 1'b0;
        end
        exp_q.push_back((we || exp_err) ? 32'd0 : ld);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        clk_stall  = 1'b0;
        read_data  = $urandom;
        #1;
        check("ready_at_req", 32'(req_ready), 32'd1);

        for (int c = 1; c <= resp_c + 1; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            clk_stall  = !mis && !never && (c >= 1 + rd) && (c <= rd + len);
            read_data  = (c >= 1 + rd + len) ? ld : $urandom;
            #1;
            if (memread || memwrite) strobes++;
            if (c == 1)
                check("strobe", {30'd0, memread, memwrite}, mis ? 32'd0 : {30'd0, !we, we});
            if (c <= resp_c)
                held_ok = held_ok && (addr == a) && (write_data == wd) && (sign_mask == m);
            check("resp_valid", 32'(resp_valid), 32'(c == resp_c));
            if (c == resp_c) begin
                exp_rdata = exp_q.pop_front();
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
            end
        end
        check("strobe_count", 32'(strobes), mis ? 32'd0 : 32'd1);
        check("held_payload", 32'(held_ok), 32'd1);
        check("back_to_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        // Reset block
        #1;
        check("rst_strobes", {30'd0, memread, memwrite}, 32'd0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_mask", 32'(sign_mask), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed: LW, SB, timeout, misaligned halfword
        run_access(1'b0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 1, 2, 1'b0);
        run_access(1'b1, 3'b000, 32'h1001, 32'h000000A5, $urandom, 1, 2, 1'b0);
        run_access(1'b0, 3'b010, 32'h2000, 32'h0, $urandom, 1, 2, 1'b1);
        run_access(1'b0, 3'b001, 32'h1003, 32'h0, 32'h0000BEEF, 1, 2, 1'b0);

        // clk_stall high at request: no handshake until it drops
        @(negedge clk);
        clk_stall = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h3000;
        #1;
        check("ready_stalled", 32'(req_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("no_handshake", {29'd0, o_dbg_state} | 32'(memread), 32'(ST_IDLE));
        end
        @(negedge clk);
        clk_stall = 1'b0;
        #1;
        check("ready_rise", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Reset while in WAIT_LO
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h4000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clk_stall = 1'b1;
        @(negedge clk);
        #1;
        check("pre_rst_wait_lo", 32'(o_dbg_state), 32'(ST_WAIT_LO));
        reset_n = 1'b0;
        #1;
        check("midrst_state", 32'(o_dbg_state), 32'(ST_IDLE));
        check("midrst_addr", addr, 32'd0);
        check("midrst_flags", {28'd0, memread, memwrite, resp_valid, resp_err}, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {30'd0, resp_valid, req_ready}, 32'd0);
        end
        @(negedge clk);
        clk_stall = 1'b0;
        #1;
        check("post_rst_ready", {30'd0, resp_valid, req_ready}, 32'd1);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(1, 3), $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
